// File: rtl/uart_cmd_pkg.sv
// Shared command, payload and view encodings for the UART command front-end.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        CMD_DATA   = 2'd0,
        CMD_CONFIG = 2'd1,
        CMD_PREDIV = 2'd2,
        CMD_VIEW   = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        VIEW_HB     = 2'd0,
        VIEW_DATA   = 2'd1,
        VIEW_PREDIV = 2'd2,
        VIEW_STATUS = 2'd3
    } view_e;

    localparam logic [4:0] CFG_RESET_PAYLOAD = 5'b11000;

endpackage

// File: rtl/uart_cmd_filter.sv
// Glitch filter: registers the command pins and raises a one-shot fire once a new value
// has been seen on STABLE_CYCLES+1 consecutive edges.
module uart_cmd_filter #(
    parameter int STABLE_CYCLES = 2,
    parameter int IN_W          = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IN_W-1:0] i_in,
    output logic            o_fire,
    output logic [6:0]      o_sample
);

    localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [6:0]       w_in;
    logic [6:0]       r_sample;
    logic [6:0]       r_last_cmd;
    logic [CNT_W-1:0] r_stab_cnt;

    assign w_in = i_in[6:0];

    // last_cmd is loaded at reset so whatever sits on the pins then is never executed
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample   <= w_in;
            r_last_cmd <= w_in;
            r_stab_cnt <= '0;
        end else begin
            r_sample <= w_in;
            if (w_in != r_sample) begin
                r_stab_cnt <= '0;
            end else if (r_stab_cnt != CNT_MAX) begin
                r_stab_cnt <= r_stab_cnt + CNT_W'(1);
            end
            if (o_fire) begin
                r_last_cmd <= r_sample;
            end
        end
    end

    assign o_fire   = (r_stab_cnt == CNT_MAX) && (r_sample != r_last_cmd);
    assign o_sample = r_sample;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command front-end: filtered command decode, nibble assembly of data and prescaler
// words, config register, baud tick generator and a registered debug view.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int                  IN_W          = 7,
    parameter int                  OUT_W         = 8,
    parameter int                  DATA_W        = 8,
    parameter int                  PREDIV_W      = 8,
    parameter logic [PREDIV_W-1:0] PREDIV_RESET  = '0,
    parameter int                  STABLE_CYCLES = 2,
    parameter int                  HB_W          = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_W-1:0]     io_in,
    output logic [OUT_W-1:0]    io_out,
    output logic                cfg_reset_strobe,
    output logic                cfg_gated_stop_bit,
    output logic [3:0]          cfg_bits,
    output logic                data_valid,
    output logic [DATA_W-1:0]   data_word,
    output logic [PREDIV_W-1:0] prediv_value,
    output logic                baud_tick
);

    logic                w_fire;
    logic [6:0]          w_sample;
    cmd_e                w_cmd;
    logic [4:0]          w_pay;
    logic [DATA_W-1:0]   w_data_shift;
    logic [PREDIV_W-1:0] w_prediv_shift;
    logic                w_reset_cmd;
    logic                w_prediv_commit;
    logic                w_reload;
    logic [PREDIV_W-1:0] w_reload_val;
    logic [OUT_W-1:0]    w_view_word;

    logic [DATA_W-1:0]   r_data_shadow;
    logic [PREDIV_W-1:0] r_prediv_shadow;
    logic                r_data_pending;
    logic                r_prediv_pending;
    logic [DATA_W-1:0]   r_data_word;
    logic                r_data_valid;
    logic [3:0]          r_cfg_bits;
    logic                r_strobe;
    logic [PREDIV_W-1:0] r_prediv_value;
    logic [PREDIV_W-1:0] r_div_cnt;
    logic                r_baud_tick;
    logic [HB_W-1:0]     r_hb;
    view_e               r_view;
    logic [OUT_W-1:0]    r_out;

    uart_cmd_filter #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .IN_W         (IN_W)
    ) u_filter (
        .clk     (clk),
        .reset   (reset),
        .i_in    (io_in),
        .o_fire  (w_fire),
        .o_sample(w_sample)
    );

    assign w_cmd = cmd_e'(w_sample[1:0]);
    assign w_pay = w_sample[6:2];

    // Nibbles enter at the LSB end; the cast drops whatever overflows the word
    assign w_data_shift   = DATA_W'({r_data_shadow, w_pay[3:0]});
    assign w_prediv_shift = PREDIV_W'({r_prediv_shadow, w_pay[3:0]});

    assign w_reset_cmd     = w_fire && (w_cmd == CMD_CONFIG) && (w_pay == CFG_RESET_PAYLOAD);
    assign w_prediv_commit = w_fire && (w_cmd == CMD_PREDIV) && w_pay[4];
    assign w_reload        = w_reset_cmd || w_prediv_commit;
    assign w_reload_val    = w_reset_cmd ? PREDIV_RESET : w_prediv_shift;

    always_comb begin
        w_view_word = '0;
        case (r_view)
            VIEW_HB:     w_view_word = OUT_W'(r_hb);
            VIEW_DATA:   w_view_word = OUT_W'(r_data_word);
            VIEW_PREDIV: w_view_word = OUT_W'(r_prediv_value);
            VIEW_STATUS: w_view_word = OUT_W'({r_cfg_bits, 2'b00, r_prediv_pending, r_data_pending});
            default:     w_view_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_shadow    <= '0;
            r_prediv_shadow  <= '0;
            r_data_pending   <= 1'b0;
            r_prediv_pending <= 1'b0;
            r_data_word      <= '0;
            r_data_valid     <= 1'b0;
            r_cfg_bits       <= '0;
            r_strobe         <= 1'b0;
            r_prediv_value   <= PREDIV_RESET;
            r_div_cnt        <= PREDIV_RESET;
            r_baud_tick      <= 1'b0;
            r_hb             <= '0;
            r_view           <= VIEW_HB;
            r_out            <= '0;
        end else begin
            r_data_valid <= 1'b0;
            r_strobe     <= 1'b0;
            r_baud_tick  <= 1'b0;
            r_out        <= w_view_word;

            // A reload wins over a tick that would have landed in the same cycle
            if (w_reload) begin
                r_div_cnt      <= w_reload_val;
                r_prediv_value <= w_reload_val;
            end else if (r_div_cnt == '0) begin
                r_baud_tick <= 1'b1;
                r_hb        <= r_hb + HB_W'(1);
                r_div_cnt   <= r_prediv_value;
            end else begin
                r_div_cnt <= r_div_cnt - PREDIV_W'(1);
            end

            if (w_fire) begin
                case (w_cmd)
                    CMD_DATA: begin
                        if (w_pay[4]) begin
                            r_data_word    <= w_data_shift;
                            r_data_valid   <= 1'b1;
                            r_data_shadow  <= '0;
                            r_data_pending <= 1'b0;
                        end else begin
                            r_data_shadow  <= w_data_shift;
                            r_data_pending <= 1'b1;
                        end
                    end
                    CMD_CONFIG: begin
                        if (w_reset_cmd) begin
                            r_strobe         <= 1'b1;
                            r_cfg_bits       <= '0;
                            r_data_shadow    <= '0;
                            r_prediv_shadow  <= '0;
                            r_data_pending   <= 1'b0;
                            r_prediv_pending <= 1'b0;
                        end else if (!w_pay[4]) begin
                            r_cfg_bits <= w_pay[3:0];
                        end
                    end
                    CMD_PREDIV: begin
                        if (w_pay[4]) begin
                            r_prediv_shadow  <= '0;
                            r_prediv_pending <= 1'b0;
                        end else begin
                            r_prediv_shadow  <= w_prediv_shift;
                            r_prediv_pending <= 1'b1;
                        end
                    end
                    CMD_VIEW: r_view <= view_e'(w_pay[1:0]);
                    default: ;
                endcase
            end
        end
    end

    assign io_out             = r_out;
    assign cfg_reset_strobe   = r_strobe;
    assign cfg_gated_stop_bit = r_cfg_bits[0];
    assign cfg_bits           = r_cfg_bits;
    assign data_valid         = r_data_valid;
    assign data_word          = r_data_word;
    assign prediv_value       = r_prediv_value;
    assign baud_tick          = r_baud_tick;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed vector table, corner sequences, then random traffic,
// all compared against a behavioural model of the command front-end.
module tb_uart_cmd_ctrl;

    localparam int         OUT_W        = 8;
    localparam int         DATA_W       = 8;
    localparam int         PREDIV_W     = 8;
    localparam int         HB_W         = 5;
    localparam logic [7:0] PREDIV_RESET = 8'd0;

    localparam int K_NONE   = 0;
    localparam int K_CFG    = 1;
    localparam int K_STOP   = 2;
    localparam int K_DATA   = 3;
    localparam int K_PREDIV = 4;
    localparam int K_OUT    = 5;
    localparam int K_VALID  = 6;
    localparam int K_STROBE = 7;
    localparam int K_TICK   = 8;

    typedef struct {
        logic [6:0] din;
        int         hold;
        int         kind;
        int         exp;
    } vec_t;

    logic                clk = 1'b0;
    logic                reset;
    logic [6:0]          io_in;
    logic [OUT_W-1:0]    io_out;
    logic                cfg_reset_strobe;
    logic                cfg_gated_stop_bit;
    logic [3:0]          cfg_bits;
    logic                data_valid;
    logic [DATA_W-1:0]   data_word;
    logic [PREDIV_W-1:0] prediv_value;
    logic                baud_tick;

    int total = 0;
    int bad   = 0;
    int n_valid, n_strobe, n_tick;

    // behavioural model state
    int hist[3];
    int m_last, m_t, m_anchor;
    int m_dshadow, m_dpend, m_pshadow, m_ppend;
    int m_cfg, m_word, m_valid, m_strobe, m_prediv, m_tick, m_hb, m_view, m_out;

    vec_t vecs[$];

    uart_cmd_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .io_in             (io_in),
        .io_out            (io_out),
        .cfg_reset_strobe  (cfg_reset_strobe),
        .cfg_gated_stop_bit(cfg_gated_stop_bit),
        .cfg_bits          (cfg_bits),
        .data_valid        (data_valid),
        .data_word         (data_word),
        .prediv_value      (prediv_value),
        .baud_tick         (baud_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the model: a value executes once it has been seen on three
    // consecutive edges and differs from the last executed value.
    task automatic model_step(input logic rst, input int x);
        int  cmd, p, nib, sh;
        bit  fire, reload, tick;
        m_t++;
        if (rst) begin
            hist[0] = x; hist[1] = -1; hist[2] = -2;
            m_last = x;
            m_dshadow = 0; m_dpend = 0; m_pshadow = 0; m_ppend = 0;
            m_cfg = 0; m_word = 0; m_valid = 0; m_strobe = 0;
            m_prediv = int'(PREDIV_RESET); m_anchor = m_t;
            m_tick = 0; m_hb = 0; m_view = 0; m_out = 0;
            return;
        end
        case (m_view)
            0:       m_out = m_hb;
            1:       m_out = m_word;
            2:       m_out = m_prediv;
            default: m_out = (m_cfg * 16 + m_ppend * 2 + m_dpend) % 256;
        endcase
        m_valid  = 0;
        m_strobe = 0;
        reload   = 0;
        tick     = ((m_t - m_anchor) % (m_prediv + 1)) == 0;
        fire     = (hist[0] == hist[1]) && (hist[1] == hist[2]) && (hist[0] != m_last);
        if (fire) begin
            m_last = hist[0];
            cmd = hist[0] % 4;
            p   = hist[0] / 4;
            nib = p % 16;
            case (cmd)
                0: begin
                    sh = (m_dshadow * 16 + nib) % 256;
                    if (p >= 16) begin
                        m_word = sh; m_valid = 1; m_dshadow = 0; m_dpend = 0;
                    end else begin
                        m_dshadow = sh; m_dpend = 1;
                    end
                end
                1: begin
                    if (p == 24) begin
                        m_strobe = 1; m_cfg = 0; m_prediv = int'(PREDIV_RESET);
                        m_dshadow = 0; m_pshadow = 0; m_dpend = 0; m_ppend = 0;
                        reload = 1;
                    end else if (p < 16) begin
                        m_cfg = nib;
                    end
                end
                2: begin
                    sh = (m_pshadow * 16 + nib) % 256;
                    if (p >= 16) begin
                        m_prediv = sh; m_pshadow = 0; m_ppend = 0; reload = 1;
                    end else begin
                        m_pshadow = sh; m_ppend = 1;
                    end
                end
                default: m_view = p % 4;
            endcase
        end
        if (reload) begin
            m_tick = 0;
            m_anchor = m_t;
        end else begin
            m_tick = tick ? 1 : 0;
            if (tick) m_hb = (m_hb + 1) % (1 << HB_W);
        end
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = x;
    endtask

    task automatic step(input logic rst, input logic [6:0] v);
        reset = rst;
        io_in = v;
        @(posedge clk);
        model_step(rst, int'(v));
        @(negedge clk);
        chk("model_io_out", int'(io_out), m_out);
        chk("model_cfg_bits", int'(cfg_bits), m_cfg);
        chk("model_stop_bit", int'(cfg_gated_stop_bit), m_cfg % 2);
        chk("model_data_word", int'(data_word), m_word);
        chk("model_data_valid", int'(data_valid), m_valid);
        chk("model_prediv", int'(prediv_value), m_prediv);
        chk("model_baud_tick", int'(baud_tick), m_tick);
        chk("model_strobe", int'(cfg_reset_strobe), m_strobe);
        n_valid  += int'(data_valid);
        n_strobe += int'(cfg_reset_strobe);
        n_tick   += int'(baud_tick);
    endtask

    function automatic string kind_name(input int k);
        case (k)
            K_CFG:    return "vec_cfg_bits";
            K_STOP:   return "vec_stop_bit";
            K_DATA:   return "vec_data_word";
            K_PREDIV: return "vec_prediv";
            K_OUT:    return "vec_io_out";
            K_VALID:  return "vec_valid_count";
            K_STROBE: return "vec_strobe_count";
            default:  return "vec_tick_count";
        endcase
    endfunction

    initial begin
        // io_in = {payload[4:0], cmd[1:0]}
        vecs.push_back('{7'h05,  8, K_CFG,    0});     // value present at reset never executes
        vecs.push_back('{7'h61,  1, K_NONE,   0});     // one-edge glitch of the reset command
        vecs.push_back('{7'h05,  6, K_STROBE, 0});
        vecs.push_back('{7'h28,  3, K_NONE,   0});     // data nibble A
        vecs.push_back('{7'h4C,  4, K_VALID,  1});     // last nibble 3
        vecs.push_back('{7'h4C,  1, K_DATA,   8'hA3});
        vecs.push_back('{7'h07,  5, K_OUT,    8'hA3}); // view data
        vecs.push_back('{7'h02,  3, K_NONE,   0});     // prediv nibble 0
        vecs.push_back('{7'h4E,  4, K_PREDIV, 3});     // prediv last nibble 3
        vecs.push_back('{7'h4E, 40, K_TICK,   10});
        vecs.push_back('{7'h05,  4, K_CFG,    1});
        vecs.push_back('{7'h05,  1, K_STOP,   1});
        vecs.push_back('{7'h28,  4, K_NONE,   0});     // partial data nibble
        vecs.push_back('{7'h0F,  5, K_OUT,    8'h11}); // status view: cfg=1, data pending
        vecs.push_back('{7'h61,  4, K_STROBE, 1});     // reset command
        vecs.push_back('{7'h61,  2, K_OUT,    8'h00});
        vecs.push_back('{7'h61,  1, K_PREDIV, 0});
        vecs.push_back('{7'h4C, 12, K_VALID,  1});     // held repeat executes once
        vecs.push_back('{7'h4C,  1, K_DATA,   8'h03});
        vecs.push_back('{7'h03,  4, K_NONE,   0});     // view cmd in between
        vecs.push_back('{7'h4C,  4, K_VALID,  1});     // re-executes
        vecs.push_back('{7'h4C, 32, K_TICK,   32});    // prediv 0: tick every clock

        m_t = 0;
        n_valid = 0; n_strobe = 0; n_tick = 0;
        repeat (3) step(1'b1, 7'h05);
        chk("reset_io_out", int'(io_out), 0);
        chk("reset_prediv", int'(prediv_value), int'(PREDIV_RESET));
        chk("reset_data_word", int'(data_word), 0);

        foreach (vecs[i]) begin
            n_valid = 0; n_strobe = 0; n_tick = 0;
            for (int c = 0; c < vecs[i].hold; c++) step(1'b0, vecs[i].din);
            case (vecs[i].kind)
                K_CFG:    chk(kind_name(K_CFG), int'(cfg_bits), vecs[i].exp);
                K_STOP:   chk(kind_name(K_STOP), int'(cfg_gated_stop_bit), vecs[i].exp);
                K_DATA:   chk(kind_name(K_DATA), int'(data_word), vecs[i].exp);
                K_PREDIV: chk(kind_name(K_PREDIV), int'(prediv_value), vecs[i].exp);
                K_OUT:    chk(kind_name(K_OUT), int'(io_out), vecs[i].exp);
                K_VALID:  chk(kind_name(K_VALID), n_valid, vecs[i].exp);
                K_STROBE: chk(kind_name(K_STROBE), n_strobe, vecs[i].exp);
                K_TICK:   chk(kind_name(K_TICK), n_tick, vecs[i].exp);
                default: ;
            endcase
        end

        // prediv=3 commits landing at every phase of the divider, including on a tick
        for (int d = 0; d < 4; d++) begin
            repeat (3 + d) step(1'b0, 7'h02);
            repeat (5) step(1'b0, 7'h4E);
        end

        // global reset in the middle of data assembly
        repeat (4) step(1'b0, 7'h28);
        step(1'b1, 7'h28);
        chk("midreset_io_out", int'(io_out), 0);
        chk("midreset_prediv", int'(prediv_value), int'(PREDIV_RESET));
        repeat (5) step(1'b0, 7'h0F);
        chk("midreset_status", int'(io_out), 0);

        // random traffic against the model
        for (int n = 0; n < 900; n++) begin
            logic [6:0] v;
            int         hold;
            v = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 9) == 0) v = 7'h61;
            if ($urandom_range(0, 3) == 0) v[6] = 1'b0;
            hold = $urandom_range(1, 5);
            if ($urandom_range(0, 99) == 0) step(1'b1, v);
            for (int c = 0; c < hold; c++) step(1'b0, v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
